// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encoding, default width
// and the fixed accept-to-done latency used by the stall logic.
package div_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem, dvd_msb};
    assign trial   = shifted - {1'b0, divisor};

    // With the shifted top bit set the partial remainder already exceeds any
    // divisor; otherwise the borrow out of the subtract decides.
    assign q_bit    = shifted[WIDTH] | ~trial[WIDTH];
    assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Multi-cycle signed/unsigned restoring divider with start/working/done
// handshake. Operands are reduced to magnitudes, divided one bit per cycle,
// and the signs are reapplied before the result registers are loaded.
//
//   state | meaning
//   IDLE  | waiting for div
//   PREP  | form magnitudes and signs, catch divide-by-zero
//   RUN   | one quotient bit per cycle, WIDTH cycles
//   FIX   | reapply signs, load result registers
//   DONE  | one-cycle done pulse, may accept next request
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             working,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic             sgn_r;
    logic [WIDTH-1:0] dvd, divisor, rem;
    logic             q_sign, r_sign;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] next_rem;
    logic             q_bit;
    logic             accept;

    assign accept = div && ((state == IDLE) || (state == DONE));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .divisor  (divisor),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state, working and done decode; working rises combinationally on
    // the accepting cycle so the stall lands in the same cycle as the request.
    always_comb begin
        state_nxt = state;
        working   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (div) begin
                    state_nxt = PREP;
                    working   = 1'b1;
                end
            end
            PREP: begin
                working   = 1'b1;
                state_nxt = (b_r == '0) ? DONE : RUN;
            end
            RUN: begin
                working = 1'b1;
                if (count == LAST) state_nxt = FIX;
            end
            FIX: begin
                working   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (div) begin
                    state_nxt = PREP;
                    working   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and held result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r       <= '0;
            b_r       <= '0;
            sgn_r     <= 1'b0;
            dvd       <= '0;
            divisor   <= '0;
            rem       <= '0;
            q_sign    <= 1'b0;
            r_sign    <= 1'b0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_r   <= a;
                        b_r   <= b;
                        sgn_r <= sgn;
                    end
                end
                PREP: begin
                    dvd     <= (sgn_r && a_r[WIDTH-1]) ? -a_r : a_r;
                    divisor <= (sgn_r && b_r[WIDTH-1]) ? -b_r : b_r;
                    rem     <= '0;
                    count   <= '0;
                    q_sign  <= sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    r_sign  <= sgn_r & a_r[WIDTH-1];
                    if (b_r == '0) begin
                        quotient  <= '1;
                        remainder <= a_r;
                        dz        <= 1'b1;
                    end
                end
                RUN: begin
                    rem   <= next_rem;
                    dvd   <= {dvd[WIDTH-2:0], q_bit};
                    count <= count + 1'b1;
                end
                FIX: begin
                    quotient  <= q_sign ? -dvd : dvd;
                    remainder <= r_sign ? -rem : rem;
                    dz        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the iterative divider: fixed vector table, random
// operands against an arithmetic reference, and handshake/reset sequences.
module tb_divider;
    import div_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, div, sgn;
    logic [W-1:0] a, b;
    logic         working, done, dz;
    logic [W-1:0] quotient, remainder;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .div       (div),
        .sgn       (sgn),
        .a         (a),
        .b         (b),
        .working   (working),
        .done      (done),
        .dz        (dz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sx, sy;
        if (y == '0) begin
            q = '1; r = x; z = 1'b1;
        end else if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q = W'(sx / sy);
            r = W'(sx % sy);
            z = 1'b0;
        end else begin
            q = x / y; r = x % y; z = 1'b0;
        end
    endfunction

    // Called at a negedge: present a request; the next posedge accepts it.
    task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        a = x; b = y; sgn = s; div = 1'b1;
        #1;
        check("accept_working", working, 1'b1);
    endtask

    // Counts negedges until done; keeps div high (scrambling operands) for
    // the first `hold` cycles. wk_ok drops if working falls before done.
    task automatic wait_done(input int hold, output int lat, output logic wk_ok);
        lat = -1;
        wk_ok = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i > hold) div = 1'b0;
            else begin
                a = $urandom; b = $urandom; sgn = ~sgn;
            end
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (!working) wk_ok = 1'b0;
        end
        if (lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done, expected done within 100 cycles");
        end
    endtask

    task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int   lat;
        logic wk;
        start(x, y, s);
        wait_done(0, lat, wk);
        check("latency", lat, (y == '0) ? 2 : DIV_LATENCY);
        check("working_span", wk, 1'b1);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("dz", dz, ez);
    endtask

    vec_t vecs[$];

    initial begin
        int   lat;
        logic wk, no_done;
        logic [W-1:0] x, y, eq, er;
        logic s, ez;

        vecs.push_back('{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0});
        vecs.push_back('{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0});
        vecs.push_back('{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0});
        vecs.push_back('{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0});
        vecs.push_back('{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000,  1'b0});
        vecs.push_back('{32'h12345678,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h12345678,  1'b1});
        vecs.push_back('{32'd1000,      32'd10,        1'b0, 32'd100,       32'd0,         1'b0});
        vecs.push_back('{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         1'b0});
        vecs.push_back('{32'hFFFFFFFF,  32'd2,         1'b0, 32'h7FFFFFFF,  32'd1,         1'b0});
        vecs.push_back('{32'd0,         32'd5,         1'b1, 32'd0,         32'd0,         1'b0});
        vecs.push_back('{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 32'd3,         32'hFFFFFFFF,  1'b0});
        vecs.push_back('{32'h80000000,  32'd0,         1'b1, 32'hFFFFFFFF,  32'h80000000,  1'b1});
        vecs.push_back('{32'd5,         32'hFFFFFFFF,  1'b0, 32'd0,         32'd5,         1'b0});
        vecs.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'd1,         32'd0,         1'b0});

        reset = 1'b1; div = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_working", working, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", dz, 1'b0);
        check("rst_quotient", quotient, '0);
        check("rst_remainder", remainder, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_one(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].z);
            @(negedge clk);
            #1;
            check("done_one_cycle", done, 1'b0);
        end

        // Randomized operands, with occasional back-to-back starts.
        for (int n = 0; n < 40; n++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = '0;
                1:       y = W'($urandom_range(1, 15));
                2:       y = $urandom;
                default: y = -W'($urandom_range(1, 15));
            endcase
            s = 1'($urandom_range(0, 1));
            ref_div(x, y, s, eq, er, ez);
            run_one(x, y, s, eq, er, ez);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);

        // Held div with operands changing during the run: no restart, original operands used.
        start(32'd1000, 32'd10, 1'b0);
        wait_done(20, lat, wk);
        check("held_latency", lat, DIV_LATENCY);
        check("held_working", wk, 1'b1);
        check("held_quotient", quotient, 32'd100);
        check("held_remainder", remainder, 32'd0);

        // Back-to-back: new request in the DONE cycle.
        div = 1'b0;
        @(negedge clk);
        run_one(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        start(32'd50, 32'd5, 1'b0);
        wait_done(0, lat, wk);
        check("b2b_latency", lat, DIV_LATENCY);
        check("b2b_quotient", quotient, 32'd10);
        check("b2b_remainder", remainder, 32'd0);
        @(negedge clk);

        // Results held across a new start; then reset in the middle of RUN.
        start(32'd1000, 32'd7, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            div = 1'b0;
            if (i == 5) begin
                #1;
                check("hold_quotient", quotient, 32'd10);
                check("hold_working", working, 1'b1);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_working", working, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_quotient", quotient, '0);
        check("midrst_remainder", remainder, '0);
        check("midrst_dz", dz, 1'b0);
        no_done = 1'b1;
        repeat (60) begin
            @(negedge clk);
            #1;
            if (done || working) no_done = 1'b0;
        end
        check("midrst_no_done", no_done, 1'b1);

        run_one(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
